// File: rtl/hub75_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hub75_scan_ctrl
// Description : HUB75 row/bitplane scan sequencer. Issues shift requests to
//               the colour shifter and drives panel OE and row select. Also
//               applies binary-coded modulation with global brightness scaling
//               and configurable blanking, and swaps frame buffers at frame
//               boundaries.
//               Optional macro HUB75_SCAN_OVERLAP_EN: shift the next plane
//               while the current one is displayed.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_scan_ctrl #(
  parameter int hpixel_p     = 64,
  parameter int vpixel_p     = 64,
  parameter int bpp_p        = 8,
  parameter int segments_p   = 2,
  parameter int wait_width_p = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_enable,
  input  logic [wait_width_p-1:0]                i_base_wait,
  input  logic [wait_width_p-1:0]                i_blank_interval,
  input  logic [7:0]                             i_brightness,
  output logic                                   o_tx_start,
  input  logic                                   i_tx_ready,
  output logic [$clog2(hpixel_p*vpixel_p)-1:0]   o_init_addr,
  output logic [$clog2(bpp_p)-1:0]               o_pix_bit,
  output logic                                   o_oe_n,
  output logic [$clog2(vpixel_p/segments_p)-1:0] o_row_sel,
  input  logic                                   i_swap_req,
  output logic                                   o_swap_ack,
  output logic                                   o_buf_sel,
  output logic                                   o_frame_done
);

  localparam int ROWS_P = vpixel_p / segments_p;
  localparam int ADDR_W = $clog2(hpixel_p * vpixel_p);
  localparam int BIT_W  = $clog2(bpp_p);
  localparam int ROW_W  = $clog2(ROWS_P);
  // Wide enough for (base << (bpp-1)) * 256 without any truncation.
  localparam int FULL_W = wait_width_p + bpp_p + 9;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(bpp_p - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS_P - 1);

`ifdef HUB75_SCAN_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHIFT      = 3'd1,
    SHIFT_WAIT = 3'd2,
    BLANK      = 3'd3,
    DISPLAY    = 3'd4,
    ADVANCE    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [ROW_W-1:0]    shift_row_q, shift_row_d;
  logic [FULL_W-1:0]   cnt_q, cnt_d;
  logic                guard_q, guard_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BIT_W-1:0]    pix_bit_q, pix_bit_d;
  logic [ROW_W-1:0]    row_sel_q, row_sel_d;
  logic                tx_start_q, tx_start_d;
  logic                oe_n_q, oe_n_d;
  logic                swap_ack_q, swap_ack_d;
  logic                buf_sel_q, buf_sel_d;
  logic                frame_done_q, frame_done_d;

  logic                bit_wrap_w;
  logic                frame_end_w;
  logic [BIT_W-1:0]    next_bit_w;
  logic [ROW_W-1:0]    next_row_w;
  logic [ADDR_W-1:0]   cur_addr_w;
  logic [ADDR_W-1:0]   next_addr_w;
  logic [FULL_W-1:0]   shifted_w;
  logic [FULL_W-1:0]   scale_w;
  logic [FULL_W-1:0]   prod_w;
  logic [FULL_W-1:0]   on_time_w;

  // Plane/row successor and the addresses handed to the shifter.
  always_comb begin
    bit_wrap_w  = (bit_q == LAST_BIT);
    frame_end_w = bit_wrap_w && (row_q == LAST_ROW);
    next_bit_w  = bit_wrap_w ? '0 : bit_q + BIT_W'(1);
    next_row_w  = row_q;
    if (bit_wrap_w) begin
      next_row_w = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
    end
    cur_addr_w  = ADDR_W'(int'(row_q) * hpixel_p);
    next_addr_w = ADDR_W'(int'(next_row_w) * hpixel_p);
  end

  // Binary-weighted on-time of the current plane, scaled by brightness/256.
  always_comb begin
    shifted_w = FULL_W'(i_base_wait) << bit_q;
    scale_w   = FULL_W'(i_brightness) + FULL_W'(1);
    prod_w    = shifted_w * scale_w;
    on_time_w = prod_w >> 8;
  end

  // Scan sequencer next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    bit_d        = bit_q;
    shift_row_d  = shift_row_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    pix_bit_d    = pix_bit_q;
    row_sel_d    = row_sel_q;
    buf_sel_d    = buf_sel_q;
    tx_start_d   = 1'b0;
    swap_ack_d   = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_enable) state_d = SHIFT;
      end

      SHIFT: begin
        if (!i_enable) begin
          state_d = IDLE;
        end else if (i_tx_ready) begin
          tx_start_d  = 1'b1;
          addr_d      = cur_addr_w;
          pix_bit_d   = bit_q;
          shift_row_d = row_q;
          state_d     = SHIFT_WAIT;
        end
      end

      // The first cycle is skipped: the shifter has not seen the start yet
      // and its ready is still the stale idle level.
      SHIFT_WAIT: begin
        if (!guard_q && i_tx_ready) begin
          if (i_enable) begin
            state_d   = BLANK;
            cnt_d     = FULL_W'(i_blank_interval);
            row_sel_d = shift_row_q;
          end else begin
            state_d = IDLE;
          end
        end
      end

      BLANK: begin
        if (!i_enable) begin
          state_d = IDLE;
        end else if (cnt_q <= FULL_W'(1)) begin
          state_d = DISPLAY;
          cnt_d   = on_time_w;
          if (OVERLAP) begin
            tx_start_d  = 1'b1;
            addr_d      = next_addr_w;
            pix_bit_d   = next_bit_w;
            shift_row_d = next_row_w;
          end
        end else begin
          cnt_d = cnt_q - FULL_W'(1);
        end
      end

      // With overlap a transfer is in flight here, so drain it first.
      DISPLAY: begin
        if (!i_enable) begin
          state_d = OVERLAP ? SHIFT_WAIT : IDLE;
        end else if (cnt_q <= FULL_W'(1)) begin
          state_d = ADVANCE;
        end else begin
          cnt_d = cnt_q - FULL_W'(1);
        end
      end

      ADVANCE: begin
        if (!i_enable) begin
          state_d = OVERLAP ? SHIFT_WAIT : IDLE;
        end else begin
          bit_d = next_bit_w;
          row_d = next_row_w;
          if (frame_end_w) begin
            frame_done_d = 1'b1;
            if (i_swap_req) begin
              swap_ack_d = 1'b1;
              buf_sel_d  = ~buf_sel_q;
            end
          end
          state_d = OVERLAP ? SHIFT_WAIT : SHIFT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // IDLE is only reached through enable loss: restart the scan at plane 0.
    if (state_d == IDLE) begin
      row_d     = '0;
      bit_d     = '0;
      row_sel_d = '0;
    end

    guard_d = (state_d == SHIFT_WAIT) && (state_q != SHIFT_WAIT);
    oe_n_d  = !((state_d == DISPLAY) && (cnt_d != '0));
  end

  // State and output registers; reset blanks the panel immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      bit_q        <= '0;
      shift_row_q  <= '0;
      cnt_q        <= '0;
      guard_q      <= 1'b0;
      addr_q       <= '0;
      pix_bit_q    <= '0;
      row_sel_q    <= '0;
      tx_start_q   <= 1'b0;
      oe_n_q       <= 1'b1;
      swap_ack_q   <= 1'b0;
      buf_sel_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      bit_q        <= bit_d;
      shift_row_q  <= shift_row_d;
      cnt_q        <= cnt_d;
      guard_q      <= guard_d;
      addr_q       <= addr_d;
      pix_bit_q    <= pix_bit_d;
      row_sel_q    <= row_sel_d;
      tx_start_q   <= tx_start_d;
      oe_n_q       <= oe_n_d;
      swap_ack_q   <= swap_ack_d;
      buf_sel_q    <= buf_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_tx_start   = tx_start_q;
  assign o_init_addr  = addr_q;
  assign o_pix_bit    = pix_bit_q;
  assign o_oe_n       = oe_n_q;
  assign o_row_sel    = row_sel_q;
  assign o_swap_ack   = swap_ack_q;
  assign o_buf_sel    = buf_sel_q;
  assign o_frame_done = frame_done_q;

endmodule
`default_nettype wire
